// File: rtl/i2c_target_rx.sv
// I2C target receive engine: START/STOP detection, 7-bit address match, write-byte capture with
// SCL stretching until the consumer accepts. Optional stretch timeout under I2C_STRETCH_TIMEOUT_EN.
`timescale 1ns/1ps
module i2c_target_rx #(
  parameter logic [6:0]  ADDR        = 7'h50,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TIMEOUT     = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addr_match,
  output logic       busy
`ifdef I2C_STRETCH_TIMEOUT_EN
  ,
  output logic       stretch_to
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_DATA, S_STRETCH, S_ACK_D, S_IGNORE
  } state_t;

  state_t state, state_n;

  // Top bit of each chain is the previous value of the synchronized level.
  logic [SYNC_STAGES:0] scl_sr, sda_sr;
  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;

  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] shreg, sh_n;
  logic [7:0] pend_data;
  logic       pend_valid;
  logic       scl_oe_n, sda_oe_n, am_n, busy_n;
  logic       byte_load, hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-1:0], scl_in};
      sda_sr <= {sda_sr[SYNC_STAGES-1:0], sda_in};
    end
  end

  assign scl_s    = scl_sr[SYNC_STAGES-1];
  assign scl_p    = scl_sr[SYNC_STAGES];
  assign sda_s    = sda_sr[SYNC_STAGES-1];
  assign sda_p    = sda_sr[SYNC_STAGES];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;
  assign hs       = rx_valid & rx_ready;

`ifdef I2C_STRETCH_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;
  assign to_hit = (state == S_STRETCH) && (to_cnt == TIMEOUT - 16'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = bit_cnt;
    sh_n      = shreg;
    scl_oe_n  = scl_oe;
    sda_oe_n  = sda_oe;
    am_n      = addr_match;
    busy_n    = busy;
    byte_load = 1'b0;
    if (start_c) begin
      state_n  = S_ADDR;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
      scl_oe_n = 1'b0;
      am_n     = 1'b0;
      busy_n   = 1'b1;
    end else if (stop_c) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      scl_oe_n = 1'b0;
      am_n     = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            sh_n  = {shreg[6:0], sda_s};
            cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (state == S_ADDR) begin
              // Only a write to our own address is acknowledged; reads are NACKed.
              if (shreg == {ADDR, 1'b0}) begin
                state_n  = S_ACK_A;
                sda_oe_n = 1'b1;
                am_n     = 1'b1;
              end else begin
                state_n  = S_IGNORE;
                sda_oe_n = 1'b0;
              end
            end else begin
              byte_load = 1'b1;
              scl_oe_n  = 1'b1;
              state_n   = S_STRETCH;
            end
          end
        end
        S_ACK_A, S_ACK_D: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            cnt_n    = 4'd0;
            state_n  = S_DATA;
          end
        end
        S_STRETCH: begin
          // ACK is driven while SCL is still held low so it meets setup before release.
          if ((hs && !pend_valid) || !rx_valid) begin
            scl_oe_n = 1'b0;
            sda_oe_n = 1'b1;
            state_n  = S_ACK_D;
          end
`ifdef I2C_STRETCH_TIMEOUT_EN
          else if (to_hit) begin
            scl_oe_n = 1'b0;
            sda_oe_n = 1'b0;
            state_n  = S_IGNORE;
          end
`endif
        end
        S_IDLE, S_IGNORE: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'd0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      shreg      <= sh_n;
      scl_oe     <= scl_oe_n;
      sda_oe     <= sda_oe_n;
      addr_match <= am_n;
      busy       <= busy_n;
    end
  end

  // A byte that lands while the previous one is unconsumed waits in pend_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      pend_data  <= 8'd0;
      pend_valid <= 1'b0;
    end else if (byte_load) begin
      if (!rx_valid) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (hs && !pend_valid) begin
        rx_data <= shreg;
      end else if (hs) begin
        rx_data   <= pend_data;
        pend_data <= shreg;
      end else begin
        pend_data  <= shreg;
        pend_valid <= 1'b1;
      end
    end else if (hs) begin
      if (pend_valid) begin
        rx_data    <= pend_data;
        pend_valid <= 1'b0;
      end else begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef I2C_STRETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt     <= 16'd0;
      stretch_to <= 1'b0;
    end else begin
      to_cnt <= (state == S_STRETCH && !start_c && !stop_c) ? to_cnt + 16'd1 : 16'd0;
      if (start_c)
        stretch_to <= 1'b0;
      else if (to_hit && !stop_c && !((hs && !pend_valid) || !rx_valid))
        stretch_to <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: an open-drain bus master model drives SCL/SDA and checks
// ACKs, delivered bytes, stretch length and reset behaviour.
`timescale 1ns/1ps
module tb_i2c_target_rx;
  localparam int QT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       rx_ready = 1'b0;
  logic       scl_oe, sda_oe, rx_valid, addr_match, busy;
  logic [7:0] rx_data;
  logic       scl_line, sda_line;
`ifdef I2C_STRETCH_TIMEOUT_EN
  logic       stretch_to;
`endif

  assign scl_line = m_scl & ~scl_oe;
  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (scl_line),
    .sda_in     (sda_line),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .addr_match (addr_match),
    .busy       (busy)
`ifdef I2C_STRETCH_TIMEOUT_EN
    ,
    .stretch_to (stretch_to)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int n_scl_oe, n_rxv, n_rise;
  logic am_seen, rxv_q;
  logic [7:0] log_q[$];
  logic ack, ack1;

  // Inputs change 2 ns after posedge, so negedge sampling sees what the DUT will use.
  always @(negedge clk) begin
    if (scl_oe) n_scl_oe++;
    if (rx_valid) n_rxv++;
    if (rx_valid && !rxv_q) n_rise++;
    rxv_q = rx_valid;
    if (addr_match) am_seen = 1'b1;
    if (rx_valid && rx_ready) log_q.push_back(rx_data);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic q(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_mon();
    n_scl_oe = 0; n_rxv = 0; n_rise = 0; am_seen = 1'b0;
    log_q.delete();
  endtask

  task automatic scl_high();
    int n = 0;
    m_scl = 1'b1;
    while (scl_line !== 1'b1 && n < 2000) begin
      q(1);
      n++;
    end
    if (n >= 2000) chki("scl_stretch_bound", n, 0);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q(QT);
    scl_high();   q(QT);
    m_sda = 1'b0; q(QT);
    m_scl = 1'b0; q(QT);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q(QT);
    scl_high();   q(QT);
    m_sda = 1'b1; q(QT);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda = b; q(QT);
    scl_high(); q(QT);
    s = sda_line;
    m_scl = 1'b0; q(QT);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    a = ~s;
  endtask

  initial begin
    logic s;
    int n;
    clear_mon();
    rxv_q = 1'b0;
    q(3);
    chk1("rst_scl_oe", scl_oe, 1'b0);
    chk1("rst_sda_oe", sda_oe, 1'b0);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_addr_match", addr_match, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    q(5);

    // Basic write: 0xA0 then 0xA5 with consumer always ready.
    clear_mon(); rx_ready = 1'b1;
    bus_start();
    chk1("t1_busy_after_start", busy, 1'b1);
    send_byte(8'hA0, ack);
    chk1("t1_addr_ack", ack, 1'b1);
    chk1("t1_addr_match", addr_match, 1'b1);
    send_byte(8'hA5, ack);
    chk1("t1_data_ack", ack, 1'b1);
    chki("t1_scl_oe_cycles", n_scl_oe, 1);
    chki("t1_rx_valid_cycles", n_rxv, 1);
    chki("t1_bytes", log_q.size(), 1);
    if (log_q.size() > 0) chk8("t1_byte0", log_q[0], 8'hA5);
    bus_stop(); q(6);
    chk1("t1_busy_after_stop", busy, 1'b0);
    chk1("t1_am_after_stop", addr_match, 1'b0);

    // Address mismatch: nothing acknowledged or delivered.
    clear_mon();
    bus_start();
    send_byte(8'hA2, ack);
    chk1("t2_addr_nack", ack, 1'b0);
    send_byte(8'h33, ack);
    chk1("t2_data_nack", ack, 1'b0);
    chki("t2_rx_valid_cycles", n_rxv, 0);
    chk1("t2_am_seen", am_seen, 1'b0);
    bus_stop(); q(6);

    // Read to own address is NACKed and the rest ignored until STOP.
    clear_mon();
    bus_start();
    send_byte(8'hA1, ack);
    chk1("t3_read_nack", ack, 1'b0);
    chk1("t3_addr_match", addr_match, 1'b0);
    chk1("t3_busy_ignore", busy, 1'b1);
    send_byte(8'h00, ack);
    chk1("t3_ignore_nack", ack, 1'b0);
    bus_stop(); q(6);
    chk1("t3_busy_after_stop", busy, 1'b0);

    // Consumer stalls 200 clk on the first byte; SCL stays low, no early ACK.
    clear_mon(); rx_ready = 1'b0;
    bus_start();
    send_byte(8'hA0, ack);
    chk1("t4_addr_ack", ack, 1'b1);
    fork
      send_byte(8'h11, ack1);
      begin
        n = 0;
        while (!scl_oe && n < 1000) begin
          q(1);
          n++;
        end
        q(200);
        chk1("t4_scl_oe_held", scl_oe, 1'b1);
        chk1("t4_scl_line_low", scl_line, 1'b0);
        chk1("t4_no_early_ack", sda_oe, 1'b0);
        chk8("t4_rx_data_stall", rx_data, 8'h11);
        rx_ready = 1'b1;
      end
    join
    chk1("t4_ack_11", ack1, 1'b1);
    chki("t4_scl_oe_cycles", n_scl_oe, 201);
    send_byte(8'h22, ack);
    chk1("t4_ack_22", ack, 1'b1);
    chki("t4_bytes", log_q.size(), 2);
    if (log_q.size() > 1) begin
      chk8("t4_byte0", log_q[0], 8'h11);
      chk8("t4_byte1", log_q[1], 8'h22);
    end
    bus_stop(); q(6);

    // Repeated START after 4 data bits discards the partial byte.
    clear_mon(); rx_ready = 1'b1;
    bus_start();
    send_byte(8'hA0, ack);
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    bus_start();
    send_byte(8'hA0, ack);
    chk1("t5_readdr_ack", ack, 1'b1);
    send_byte(8'h7E, ack);
    chk1("t5_data_ack", ack, 1'b1);
    chki("t5_rx_valid_rises", n_rise, 1);
    chki("t5_bytes", log_q.size(), 1);
    if (log_q.size() > 0) chk8("t5_byte0", log_q[0], 8'h7E);
    bus_stop(); q(6);

    // Asynchronous reset while stretching.
    clear_mon(); rx_ready = 1'b0;
    bus_start();
    send_byte(8'hA0, ack);
    fork
      send_byte(8'h5A, ack1);
      begin
        n = 0;
        while (!scl_oe && n < 1000) begin
          q(1);
          n++;
        end
        q(10);
        chk1("t6_stretching", scl_oe, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("t6_rst_scl_oe", scl_oe, 1'b0);
        chk1("t6_rst_sda_oe", sda_oe, 1'b0);
        chk1("t6_rst_rx_valid", rx_valid, 1'b0);
        q(2);
        rst_n = 1'b1;
      end
    join
    chk1("t6_no_ack", ack1, 1'b0);
    bus_stop(); q(6);
    chk1("t6_busy_end", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- I2C target (slave) receive engine. It is the responder end of the bus driven by the master clock/stretch generator.
- Detects START/STOP, matches the 7-bit address, ACKs, and shifts in write bytes.
- Holds SCL low (clock stretching) until the local consumer accepts each byte through a valid/ready handshake.
- Sits between the open-drain pad cells and the register-file write port.

Parameters:
- ADDR, 7'h50, own 7-bit target address.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (legal values 2..3).
- TIMEOUT, 16'd50000, stretch timeout in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock (oversamples SCL by at least 8x).
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  SCL pad level (asynchronous).
- sda_in  input  1  SDA pad level (asynchronous).
- scl_oe  output  1  1 = pull SCL low (stretch).
- sda_oe  output  1  1 = pull SDA low (ACK).
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- addr_match  output  1  high from the address ACK until STOP or repeated START.
- busy  output  1  high between a detected START and a detected STOP.

Behaviour:
- Reset (rst_n=0, asynchronous): scl_oe=0, sda_oe=0, rx_data=0, rx_valid=0, addr_match=0, busy=0, state=IDLE, bit counter=0. Synchronizer flops reset to 1 (idle bus).
- Synchronization and edges:
  - scl_s/sda_s are the SYNC_STAGES-deep synchronized inputs. One extra flop gives the previous value.
  - SCL rise/fall = scl_s != prev. Edge detection latency is SYNC_STAGES+1 clk.
- Bus conditions:
  - START = sda_s falls while scl_s=1 and prev scl=1.
  - STOP = sda_s rises while scl_s=1 and prev scl=1.
  - Both are recognised in every state and override the FSM.
  - START (including repeated START) -> ADDR, bit counter=0, sda_oe=0, scl_oe=0, addr_match=0, busy=1.
  - STOP -> IDLE, busy=0, addr_match=0, sda_oe=0, scl_oe=0. An rx_valid already pending is kept until consumed.
- FSM states: IDLE, ADDR, ACK_A, DATA, STRETCH, ACK_D, IGNORE.
  - Bit handling:
    - Bits are sampled MSB-first on SCL rise.
    - The counter increments on SCL rise, and a byte is complete on the SCL fall after the 8th rise.
  - ADDR, byte complete:
    - Upper 7 bits == ADDR and R/W bit == 0 -> ACK_A, sda_oe=1, addr_match=1.
    - Otherwise -> IGNORE, sda_oe=0.
    - Read requests are NACKed.
  - ACK_A: on the next SCL fall, sda_oe=0 -> DATA, counter=0.
  - DATA, byte complete:
    - rx_valid=0 -> load rx_data, rx_valid=1, scl_oe=1 -> STRETCH.
    - rx_valid=1 (previous byte unconsumed) -> scl_oe=1 -> STRETCH. The new byte is held internally and loaded when the old one is consumed.
  - STRETCH:
    - scl_oe stays 1 while any byte is not yet accepted.
    - The cycle after the final accepted handshake: scl_oe=0, sda_oe=1 -> ACK_D.
    - sda_oe is driven while SCL is held low, so setup time is met.
  - ACK_D: on SCL fall, sda_oe=0 -> DATA, counter=0.
  - IGNORE: outputs released. Wait for START/STOP.
- Handshake:
  - rx_valid clears the cycle after rx_valid & rx_ready.
  - rx_data is stable while rx_valid=1.
  - rx_ready held high -> stretch lasts exactly 1 clk beyond detection.
- Glitch rule: SDA changes while SCL is high in the middle of a byte are START/STOP by definition. No bit is lost or double-counted.
- Invariants:
  - sda_oe and scl_oe never change on the same clk as a detected SCL rise.
  - scl_oe is never asserted outside STRETCH.

Optional Feature:
- Macro: I2C_STRETCH_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in STRETCH. Reaching TIMEOUT releases scl_oe and goes to IGNORE with no ACK (NACK).
  - The pending byte stays in rx_data/rx_valid.
  - A sticky internal flag, cleared by the next START, is readable as port stretch_to (output, 1).
- Undefined: stretch is unbounded, and the stretch_to port and counter are absent.

Test Plan:
- START, addr 0xA0 (0x50 write), data 0xA5, rx_ready=1, STOP -> addr ACK and data ACK seen (SDA low on 9th clocks), rx_data=0xA5 with a 1-cycle rx_valid, scl_oe pulse of 1 clk, busy back to 0 after STOP.
- Addr 0xA2 (mismatch) followed by 0x33 -> no ACK on either byte, rx_valid never asserts, addr_match=0.
- Addr 0xA1 (read to own address) -> NACK, state IGNORE until STOP.
- Data 0x11 then 0x22 with rx_ready=0 for 200 clk -> SCL held low for the 200 clk after the first byte. Release; 0x11 then 0x22 are delivered in order, each ACKed only after acceptance.
- Repeated START mid-data (after 4 bits) then addr 0xA0, data 0x7E -> partial byte discarded, single rx_valid with 0x7E.
- Assert rst_n=0 during STRETCH -> scl_oe, sda_oe and rx_valid drop immediately, asynchronously. With I2C_STRETCH_TIMEOUT_EN and TIMEOUT=100 and rx_ready=0 -> scl_oe released at 100 clk, NACK, stretch_to=1.
